// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of a 64 x 8 single-port RAM with registered read data.
// Define RAM_BURST_WRAP_EN to let bursts wrap past address 63 instead of rejecting them.
module ram_burst_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [5:0] cmd_addr,
  input  logic [5:0] cmd_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       err,
  output logic       ram_en,
  output logic       ram_wr,
  output logic [5:0] ram_addr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t     state_reg, state_next;
  logic [5:0] addr_cnt_reg;
  logic [5:0] beat_cnt_reg;
  logic       in_flight_reg;
  logic       err_reg;
  logic [7:0] fifo_mem [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;

  logic       cmd_fire;
  logic       cmd_reject;
  logic       wr_fire;
  logic       rd_issue;
  logic       push;
  logic       pop;
  logic [2:0] occ_after_pop;

`ifdef RAM_BURST_WRAP_EN
  assign cmd_reject = 1'b0;
`else
  assign cmd_reject = ({1'b0, cmd_addr} + {1'b0, cmd_len}) > 7'd63;
`endif

  assign cmd_fire = cmd_valid && (state_reg == IDLE);
  assign wr_fire  = (state_reg == WRITE) && wr_valid && !rst;
  assign push     = in_flight_reg;
  assign pop      = (count_reg != 2'd0) && rd_ready;

  // A pop in this cycle frees a slot, which keeps reads back-to-back when rd_ready is held.
  assign occ_after_pop = {1'b0, count_reg} + {2'b00, in_flight_reg} - {2'b00, pop};
  assign rd_issue      = (state_reg == READ) && !rst && (occ_after_pop < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_fire && !cmd_reject) state_next = cmd_wr ? WRITE : READ;
      WRITE:   if (wr_fire && (beat_cnt_reg == 6'd0)) state_next = IDLE;
      READ:    if (rd_issue && (beat_cnt_reg == 6'd0)) state_next = DRAIN;
      DRAIN:   if ((count_reg == 2'd0) && !in_flight_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    ram_en    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = 6'd0;
    ram_wdata = 8'd0;
    case (state_reg)
      IDLE:  begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      WRITE: wr_ready = !rst;
      default: ;
    endcase
    if (wr_fire || rd_issue) begin
      ram_en   = 1'b1;
      ram_addr = addr_cnt_reg;
    end
    if (wr_fire) begin
      ram_wr    = 1'b1;
      ram_wdata = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt_reg  <= 6'd0;
      beat_cnt_reg  <= 6'd0;
      in_flight_reg <= 1'b0;
      err_reg       <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
    end else begin
      err_reg       <= cmd_fire && cmd_reject;
      in_flight_reg <= rd_issue;
      if (cmd_fire && !cmd_reject) begin
        addr_cnt_reg <= cmd_addr;
        beat_cnt_reg <= cmd_len;
      end else if (wr_fire || rd_issue) begin
        addr_cnt_reg <= addr_cnt_reg + 6'd1;
        beat_cnt_reg <= beat_cnt_reg - 6'd1;
      end
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // RAM data is only valid the cycle after an issued read, so capture is keyed on in_flight.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    always_ff @(posedge clk) begin
      if (rst)                                fifo_mem[gi] <= 8'd0;
      else if (push && (wr_ptr_reg == 1'(gi))) fifo_mem[gi] <= ram_rdata;
    end
  end

  assign rd_valid = (count_reg != 2'd0);
  assign rd_data  = fifo_mem[rd_ptr_reg];
  assign err      = err_reg;

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 Parameters SHALL be none; geometry is fixed at 64 x 8 bit, matching the downstream single-port RAM.
REQ-002 clk  in  1  clock; all logic SHALL be on posedge clk.
REQ-003 rst  in  1  reset: synchronous, active-high.
REQ-004 cmd_valid  in  1  burst command offered.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_wr  in  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr  in  6  start address.
REQ-008 cmd_len  in  6  beats minus one (1..64 beats).
REQ-009 wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / 8  write-data stream.
REQ-010 rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / 8  read-data stream.
REQ-011 busy  out  1  burst in progress or read data still buffered.
REQ-012 err  out  1  one-cycle pulse on a rejected command.
REQ-013 ram_en, ram_wr, ram_addr[5:0], ram_wdata[7:0]  out  RAM port; ram_rdata[7:0]  in  RAM registered read data.

Function
REQ-014 The FSM SHALL have states IDLE, WRITE, READ and DRAIN.
REQ-015 cmd_ready SHALL be 1 only in IDLE; on acceptance, addr_cnt <= cmd_addr, beat_cnt <= cmd_len, then go to WRITE (cmd_wr=1) or READ (cmd_wr=0).
REQ-016 WRITE: wr_ready = 1; on each wr_valid && wr_ready, in that cycle drive ram_en=1, ram_wr=1, ram_addr=addr_cnt, ram_wdata=wr_data; then increment addr_cnt and decrement beat_cnt.
REQ-017 WRITE: after the beat where beat_cnt==0, go to IDLE; zero-latency write, one beat per cycle maximum.
REQ-018 READ: issue a read (ram_en=1, ram_wr=0, ram_addr=addr_cnt) only when buffered entries + reads in flight < 2.
REQ-019 ram_rdata SHALL be captured exactly one cycle after each issued read into a 2-entry FIFO; ram_rdata in any other cycle SHALL be ignored, because the RAM drives X when en=0.
REQ-020 rd_valid = FIFO non-empty; rd_data = FIFO head; pop on rd_valid && rd_ready.
REQ-021 Sustained read throughput with rd_ready held 1 SHALL be 1 beat per cycle; first rd_valid appears 2 cycles after command acceptance.
REQ-022 READ: after the last read is issued, go to DRAIN; DRAIN goes to IDLE when the FIFO is empty and no read is in flight.
REQ-023 Simultaneous push and pop on the FIFO SHALL keep occupancy unchanged; the FIFO SHALL never overflow, by construction of REQ-018.
REQ-024 ram_en SHALL be 0 in every cycle not named in REQ-016 and REQ-018; ram_wr=0 whenever ram_en=0.
REQ-025 addr_cnt SHALL be 6-bit and increment modulo 64; beat_cnt SHALL be 6-bit.
REQ-026 busy = (state != IDLE).

Reset
REQ-027 rst SHALL force IDLE with cmd_ready=1 and wr_ready, rd_valid, err, ram_en, ram_wr, busy = 0.
REQ-028 rst SHALL also clear ram_addr, ram_wdata, addr_cnt, beat_cnt, the FIFO and the in-flight flag to 0.
REQ-029 rst asserted mid-burst SHALL abort the burst; no further RAM access occurs and buffered read data is discarded.

Configuration
REQ-030 Macro RAM_BURST_WRAP_EN: when defined, bursts crossing address 63 SHALL wrap to 0 and continue.
REQ-031 When RAM_BURST_WRAP_EN is undefined, a command with cmd_addr + cmd_len > 63 SHALL be accepted (cmd_ready handshake) but rejected.
REQ-032 A rejected command SHALL pulse err for one cycle, cause no RAM access and no data handshake, and leave the FSM in IDLE.

Verification
REQ-033 Write addr=5, len=3, data A1..A4 with wr_valid held -> ram_en/ram_wr high 4 consecutive cycles at addresses 5,6,7,8; then IDLE.
REQ-034 Read addr=5, len=3, rd_ready=1 -> rd_data A1,A2,A3,A4 on 4 consecutive cycles, first 2 cycles after acceptance.
REQ-035 Read addr=5, len=3 with rd_ready=0 for 10 cycles -> exactly 2 reads issued, rd_data=A1 held stable; all 4 beats delivered in order after rd_ready=1.
REQ-036 Write addr=62, len=2 -> with RAM_BURST_WRAP_EN: writes to 62,63,0; without it: err pulses 1 cycle, ram_en stays 0.
REQ-037 rst asserted after 2 of 4 read beats -> next cycle rd_valid=0, ram_en=0, cmd_ready=1; a subsequent read returns correct data.
REQ-038 Write with wr_valid gapped (1,0,0,1,1,0,1) -> exactly 4 RAM writes, and ram_en=0 in the gap cycles.
